// File: rtl/sort_pkg.sv
// Shared widths and FSM state type for the sequential 4-value sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_pkg;
    localparam int DEF_W  = 3;
    localparam int NUM_IN = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SORT = 1'b1
    } state_t;
endpackage

// File: rtl/argmax4_masked.sv
// Masked 4-way argmax; lowest index wins ties, masked entries never win.
// Latency: combinational.
// Backpressure: none.
module argmax4_masked
    import sort_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]      v0,
    input  logic [W-1:0]      v1,
    input  logic [W-1:0]      v2,
    input  logic [W-1:0]      v3,
    input  logic [NUM_IN-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic [W-1:0]      max
);

    logic [W-1:0] vals [NUM_IN];
    logic         found;

    always_comb begin
        vals[0] = v0;
        vals[1] = v1;
        vals[2] = v2;
        vals[3] = v3;
        found   = 1'b0;
        idx     = '0;
        max     = '0;
        // Strict greater-than keeps the earlier (lower-index) entry on a tie.
        for (int i = 0; i < NUM_IN; i++) begin
            if (!mask[i] && (!found || vals[i] > max)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                max   = vals[i];
            end
        end
    end

endmodule

// File: rtl/sort4_seq.sv
// Accepts four values, emits them largest-first with original index, one per handshake.
// Latency: first output the cycle after accept; 4 outputs back-to-back with out_ready high.
// Backpressure: out_ready low freezes all state, so outputs hold; in_ready low while sorting.
module sort4_seq
    import sort_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    state_t                  state_q;
    state_t                  state_d;
    logic [W-1:0]            v_q [NUM_IN];
    logic [NUM_IN-1:0]       mask_q;
    logic [IDX_W-1:0]        count_q;
    logic [IDX_W-1:0]        sel_idx;
    logic [W-1:0]            sel_max;
    logic                    accept;
    logic                    fire;

    argmax4_masked #(.W(W)) u_argmax (
        .v0   (v_q[0]),
        .v1   (v_q[1]),
        .v2   (v_q[2]),
        .v3   (v_q[3]),
        .mask (mask_q),
        .idx  (sel_idx),
        .max  (sel_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                accept   = in_valid & ~rst;
                if (accept) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                out_valid = 1'b1;
                out_data  = sel_max;
                out_idx   = sel_idx;
                out_last  = (count_q == IDX_W'(NUM_IN - 1));
                fire      = out_ready;
                if (fire && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '{default: '0};
            mask_q  <= '0;
            count_q <= '0;
        end else if (accept) begin
            v_q[0]  <= a;
            v_q[1]  <= b;
            v_q[2]  <= c;
            v_q[3]  <= d;
            mask_q  <= '0;
            count_q <= '0;
        end else if (fire) begin
            // Clearing on the last output means the mask never shows all-ones in SORT.
            if (out_last) begin
                mask_q  <= '0;
                count_q <= '0;
            end else begin
                mask_q[sel_idx] <= 1'b1;
                count_q         <= count_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sort4_seq.sv
// Scoreboard bench for sort4_seq: expected outputs queued at issue, monitor pops on each handshake.
module tb_sort4_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a, b, c, d;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;

    typedef struct packed {
        logic [2:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    sort4_seq #(.W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [2:0] dat, input logic [1:0] idx, input logic last);
        exp_t e;
        e.data = dat;
        e.idx  = idx;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Called and returns at posedge+1 alignment.
    task automatic send(input logic [2:0] va, input logic [2:0] vb,
                        input logic [2:0] vc, input logic [2:0] vd);
        int waited;
        a = va; b = vb; c = vc; d = vd;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready never rose, got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    // Monitor: compares every accepted output against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: got data=%0d idx=%0d last=%0d expected none",
                         out_data, out_idx, out_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                    failures++;
                    $display("FAIL sb_out: got data=%0d idx=%0d last=%0d expected data=%0d idx=%0d last=%0d",
                             out_data, out_idx, out_last, e.data, e.idx, e.last);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid2", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;

        // Basic order with latency checks.
        out_ready = 1'b1;
        push(3'd4, 2'd3, 1'b0); push(3'd3, 2'd2, 1'b0);
        push(3'd2, 2'd1, 1'b0); push(3'd1, 2'd0, 1'b1);
        send(3'd1, 3'd2, 3'd3, 3'd4);
        chk("basic_c1_valid", out_valid, 1);
        chk("basic_c1_inrdy", in_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("basic_c5_inrdy", in_ready, 1);
        chk("basic_c5_valid", out_valid, 0);
        wait_idle("basic");

        // Mixed values, two sets back to back.
        push(3'd6, 2'd1, 1'b0); push(3'd5, 2'd0, 1'b0);
        push(3'd4, 2'd3, 1'b0); push(3'd3, 2'd2, 1'b1);
        push(3'd7, 2'd0, 1'b0); push(3'd5, 2'd3, 1'b0);
        push(3'd4, 2'd2, 1'b0); push(3'd2, 2'd1, 1'b1);
        send(3'd5, 3'd6, 3'd3, 3'd4);
        send(3'd7, 3'd2, 3'd4, 3'd5);
        wait_idle("mixed");

        // Ties resolve to ascending index; all-zero set.
        push(3'd7, 2'd2, 1'b0); push(3'd2, 2'd0, 1'b0);
        push(3'd2, 2'd1, 1'b0); push(3'd2, 2'd3, 1'b1);
        send(3'd2, 3'd2, 3'd7, 3'd2);
        push(3'd0, 2'd0, 1'b0); push(3'd0, 2'd1, 1'b0);
        push(3'd0, 2'd2, 1'b0); push(3'd0, 2'd3, 1'b1);
        send(3'd0, 3'd0, 3'd0, 3'd0);
        wait_idle("ties");

        // Backpressure: head holds for 3 cycles; in_valid during SORT ignored.
        out_ready = 1'b0;
        push(3'd6, 2'd0, 1'b0); push(3'd5, 2'd2, 1'b0);
        push(3'd3, 2'd1, 1'b0); push(3'd2, 2'd3, 1'b1);
        send(3'd6, 3'd3, 3'd5, 3'd2);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_data", out_data, 6);
            chk("bp_hold_idx", out_idx, 0);
            chk("bp_hold_last", out_last, 0);
            if (k == 1) begin
                a = 3'd1; b = 3'd1; c = 3'd1; d = 3'd1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle("bp");

        // Asynchronous reset after two outputs, then a fresh set.
        push(3'd7, 2'd3, 1'b0); push(3'd5, 2'd1, 1'b0);
        push(3'd3, 2'd0, 1'b0); push(3'd1, 2'd2, 1'b1);
        send(3'd3, 3'd5, 3'd1, 3'd7);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_data", out_data, 3);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sb_left", exp_q.size(), 2);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        push(3'd4, 2'd0, 1'b0); push(3'd3, 2'd2, 1'b0);
        push(3'd2, 2'd3, 1'b0); push(3'd1, 2'd1, 1'b1);
        send(3'd4, 3'd1, 3'd3, 3'd2);
        wait_idle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort4_seq.md
Name: sort4_seq

Overview:
- Sequential selection sorter for four W-bit unsigned values.
- Accepts one 4-value set through a valid/ready handshake.
- Emits the values in descending order, one per handshake, each tagged with its original input index (0=a, 1=b, 2=c, 3=d).
- Repeatedly drives the masked 4-way argmax comparator and consumes its 2-bit index, so it sits on the producing/consuming side of the comparator interface.

Parameters:
- W, 3, width of each input value and of out_data.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input set a..d is valid
- in_ready  output  1  block can accept a set
- a  input  W  value at index 0
- b  input  W  value at index 1
- c  input  W  value at index 2
- d  input  W  value at index 3
- out_valid  output  1  out_data/out_idx/out_last are valid
- out_ready  input  1  downstream accepts the current output
- out_data  output  W  current maximum among the remaining values
- out_idx  output  2  original index of out_data
- out_last  output  1  high on the 4th (final) output of a set

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. rst asserted forces reset state immediately, regardless of clk.
- Reset values:
  - state=IDLE; stored values v0..v3=0; used mask=4'b0000; count=0.
  - in_ready=1 (after rst deasserts), out_valid=0, out_data=0, out_idx=0, out_last=0.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready at a clk edge: capture a..d into v0..v3, clear mask, count=0, go to SORT.
  - SORT: in_ready=0, out_valid=1. Inputs a..d and in_valid are ignored.
    - out_idx = masked argmax of v0..v3 over entries with mask bit 0.
    - out_data = v[out_idx].
    - out_last = (count==3).
- Output handshake in SORT: on out_valid&out_ready, set mask[out_idx] and increment count. If out_last was 1, clear the mask and return to IDLE.
- Latency and throughput:
  - First output is valid in the cycle after the input handshake.
  - With out_ready held high, a set takes 5 cycles: 1 accept + 4 outputs.
  - No accept overlaps the last output.
- Backpressure: while out_valid&~out_ready, out_data, out_idx and out_last hold stable, because all registers are unchanged.
- Comparison and ties:
  - Comparison is unsigned on the full W bits.
  - Ties go to the lowest index, so equal values are emitted in ascending index order.
  - Masked entries never win.
  - The mask never reaches 4'b1111 while in SORT.
- Outputs are combinational from registered state and the mask. There is no combinational path from in_valid to out_*, or from out_ready to out_data.
- Reset mid-operation (during SORT, any count): return to IDLE at once, clear mask and count, drop out_valid the same instant, discard the partial set.
- in_valid asserted while in SORT: not accepted, because in_ready=0. The upstream source must hold the set until in_ready=1.

Decomposition:
- Package sort_pkg:
  - default W=3
  - NUM_IN=4
  - IDX_W=2
  - state enum {IDLE, SORT}
- Sub-module argmax4_masked (combinational):
  - inputs: v0..v3 [W-1:0], mask[3:0]
  - outputs: idx[1:0], max[W-1:0]
  - selects the lowest-index winner among unmasked entries
  - instantiated once in sort4_seq.
- FSM, value registers, mask and count live in sort4_seq.

Test Plan:
- Basic order: a,b,c,d=1,2,3,4, out_ready=1 -> (data,idx) = (4,3),(3,2),(2,1),(1,0) on cycles 1-4 after accept; out_last only on the 4th; in_ready=1 on cycle 5.
- Mixed values: 5,6,3,4 -> (6,1),(5,0),(4,3),(3,2); second set 7,2,4,5 -> (7,0),(5,3),(4,2),(2,1).
- Ties and zeros:
  - 2,2,7,2 -> (7,2),(2,0),(2,1),(2,3).
  - 0,0,0,0 -> idx 0,1,2,3 with data 0.
- Backpressure: set 6,3,5,2 with out_ready low for 3 cycles after accept -> (6,0) held stable for all 3 cycles; then (5,2),(3,1),(2,3); in_valid pulsed with 1,1,1,1 during SORT is ignored.
- Reset mid-op: set 3,5,1,7, assert rst asynchronously after 2 outputs -> out_valid=0 immediately, in_ready=1 after release; new set 4,1,3,2 -> (4,0),(3,2),(2,3),(1,1).
